// File: rtl/stream_serializer_pkg.sv
// Shared sizing helpers for the narrow-path blocks (serializer, buffer_2clk).
package stream_serializer_pkg;

  // Number of bits needed to hold the value n (0 for n == 0).
  function automatic int countbits(input int n);
    int c;
    c = 0;
    for (int i = 0; i < 31; i++) begin
      if ((n >> i) != 0) c = i + 1;
    end
    return c;
  endfunction

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow stream serializer: one WIDTH*RATIO word in, RATIO beats out,
// rlast_out on the final beat, zero-bubble between consecutive words.
//
// state | meaning
// IDLE  | no word held, ravail_out low
// SEND  | word held, presenting beat cnt_q
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*RATIO-1:0] wdata_in,
  input  logic                   wavail_in,
  output logic                   wready_in,
  output logic [WIDTH-1:0]       rdata_out,
  output logic                   rlast_out,
  output logic                   ravail_out,
  input  logic                   rready_out
);

  localparam int CW = max(countbits(RATIO - 1), 1);
  localparam int WW = WIDTH * RATIO;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   hold_q, hold_d;
  logic            busy;
  logic            last;
  logic            accept;

  assign busy       = (state_q == SEND);
  assign last       = busy & (cnt_q == CW'(RATIO - 1));
  assign ravail_out = busy;
  assign rlast_out  = last;
  // rready_out feeds wready_in combinationally so a new word lands on the last-beat cycle.
  assign wready_in  = rst & (~busy | (last & rready_out));
  assign accept     = wavail_in & wready_in;

  always_comb begin
    rdata_out = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        if (MSB_FIRST) rdata_out = hold_q[(RATIO-k)*WIDTH-1 -: WIDTH];
        else           rdata_out = hold_q[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = wdata_in;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rready_out) begin
          if (last) begin
            cnt_d = '0;
            if (accept) begin
              hold_d  = wdata_in;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule
